pixel_fb_writer: RTL and testbench
==================================

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameters: FIFO_DEPTH, default 4, pixel-buffer entries (power of two); SCREEN_W, default 160; SCREEN_H, default 120.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 x  input  8  pixel column from the drawing engine.
REQ-005 y  input  7  pixel row from the drawing engine.
REQ-006 colour  input  3  pixel colour, RGB 1 bit each.
REQ-007 writeEn  input  1  pixel-write request; a pixel transfers on a rising edge where writeEn=1 and ready=1.
REQ-008 ready  output  1  block can accept a pixel this cycle.
REQ-009 clear_req  input  1  single-cycle pulse requesting a full-screen fill.
REQ-010 clear_colour  input  3  fill colour, sampled with clear_req.
REQ-011 clear_done  output  1  one-cycle pulse when the fill completes.
REQ-012 mem_addr  output  15  framebuffer write address, registered.
REQ-013 mem_data  output  3  framebuffer write data, registered.
REQ-014 mem_we  output  1  framebuffer write strobe, registered.
REQ-015 oob_count  output  8  count of discarded out-of-range pixels, saturating.

Function
REQ-016 The block shall contain a FIFO_DEPTH-entry FIFO of {x,y,colour}; push on writeEn&&ready.
REQ-017 ready shall equal (FIFO not full) && (state==S_RUN) && !clear_pending, combinationally.
REQ-018 writeEn while ready=0 shall be ignored, with no state change.
REQ-019 In S_RUN with FIFO non-empty, the block shall pop one entry per cycle.
REQ-020 Popped pixels with x<SCREEN_W and y<SCREEN_H shall drive mem_we=1, mem_addr=y*160+x (15-bit, computed as (y<<7)+(y<<5)+x), mem_data=colour on the following edge.
REQ-021 Out-of-range popped pixels shall give mem_we=0 and increment oob_count, saturating at 255.
REQ-022 Latency: a pixel accepted at edge k into an empty FIFO shall appear on the mem port after edge k+2; sustained throughput shall be one pixel per cycle.
REQ-023 Push and pop in the same cycle shall leave the FIFO occupancy unchanged, including when the FIFO is full.
REQ-024 clear_req shall set clear_pending and latch clear_colour, and is honoured only in S_RUN; it shall be ignored in S_FLUSH and S_CLEAR.
REQ-025 writeEn and clear_req in the same accepted cycle: the pixel shall be accepted, then the clear shall proceed.
REQ-026 States: S_RUN, S_FLUSH, S_CLEAR, S_DONE.
REQ-027 S_RUN→S_FLUSH when clear_pending=1 and FIFO non-empty; S_RUN→S_CLEAR when clear_pending=1 and FIFO empty.
REQ-028 S_FLUSH shall drain the FIFO as in S_RUN, then go to S_CLEAR when it is empty.
REQ-029 S_CLEAR shall write addresses 0..19199 in ascending order, one per cycle, with mem_we=1 and mem_data=latched colour.
REQ-030 After the write to address 19199, the block shall enter S_DONE.
REQ-031 S_DONE shall assert clear_done for exactly one cycle, clear clear_pending, and return to S_RUN.
REQ-032 When no write is issued, mem_we shall be 0; mem_addr and mem_data shall hold their last values.

Reset
REQ-033 reset_n low shall asynchronously empty the FIFO, select S_RUN, and clear clear_pending, mem_we, mem_addr, mem_data, clear_done, and oob_count to 0.
REQ-034 ready shall read 1 during and after reset.
REQ-035 Reset during S_CLEAR shall abort the fill, and clear_done shall not pulse.

Structure
REQ-036 SCREEN_W, SCREEN_H, FB_DEPTH=19200, ADDR_W=15, and the state encoding shall live in shared package vga_fb_pkg.
REQ-037 The FIFO shall be a separate sub-module, pixel_fifo, with push/pop/full/empty ports.

Verification
REQ-038 Single pixel x=5, y=3, colour=3'b101 into an idle block → mem_we for one cycle, mem_addr=485, mem_data=5, two edges after acceptance.
REQ-039 Back-to-back writes (10,0), (11,0), ... for 8 cycles → 8 consecutive mem_we cycles, addresses 10..17, ready never 0.
REQ-040 x=160, y=0 then x=0, y=120 → no mem_we; oob_count=2. 300 out-of-range pixels → oob_count=255.
REQ-041 Stall mem drain by issuing clear_req with 4 pixels queued → ready=0 from the next cycle, the 4 pixels written first, then 19200 fill writes; clear_done pulses once, at cycle 19200+4+overhead.
REQ-042 writeEn and clear_req in the same cycle, and a second clear_req mid-fill → the pixel is written before the fill; the second request is ignored.
REQ-043 Assert reset_n low at fill address 1000 → mem_we=0 immediately, ready=1, no clear_done; a new pixel after release is written normally.

Source files
------------

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_pkg
// Description : Shared framebuffer geometry, pixel record layout, writer
//               state encoding and the row-major address helper used by the
//               pixel framebuffer writer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int PIX_W = X_W + Y_W + COL_W;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } fb_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

  // Row stride is fixed at 160: y*160 = y*128 + y*32, so no multiplier.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] px,
                                                input logic [Y_W-1:0] py);
    logic [ADDR_W-1:0] v_y;
    v_y     = {{(ADDR_W-Y_W){1'b0}}, py};
    fb_addr = (v_y << 7) + (v_y << 5) + {{(ADDR_W-X_W){1'b0}}, px};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous first-word-fall-through FIFO for pixel records.
//               pop_data always shows the oldest entry while !empty.
//               A push while full is accepted only if a pop happens in the
//               same cycle, so occupancy stays unchanged in that case.
// Ports       : clk, reset_n (async, active-low)
//               push, push_data  - write side
//               pop, pop_data    - read side
//               full, empty      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when indices match.
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fb_writer
// Description : Buffers pixels from a drawing engine and writes them to a
//               160x120 3-bit framebuffer. Out-of-range pixels are dropped
//               and counted. A clear request drains queued pixels, then
//               fills the whole framebuffer with one colour.
// Ports       : clk, reset_n (async, active-low)
//               x, y, colour, writeEn, ready  - pixel input handshake
//               clear_req, clear_colour       - full-screen fill request
//               clear_done                    - one-cycle fill-complete pulse
//               mem_addr, mem_data, mem_we    - registered framebuffer port
//               oob_count                     - saturating discard counter
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fb_writer
  import vga_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = vga_fb_pkg::SCREEN_W,
  parameter int SCREEN_H   = vga_fb_pkg::SCREEN_H
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [COL_W-1:0]  colour,
  input  logic              writeEn,
  output logic              ready,
  input  logic              clear_req,
  input  logic [COL_W-1:0]  clear_colour,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [COL_W-1:0]  mem_data,
  output logic              mem_we,
  output logic [7:0]        oob_count
);

  localparam logic [X_W-1:0]    c_SCREEN_W  = SCREEN_W[X_W-1:0];
  localparam logic [Y_W-1:0]    c_SCREEN_H  = SCREEN_H[Y_W-1:0];
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fb_state_t         r_state;
  logic              r_clear_pending;
  logic [COL_W-1:0]  r_clear_colour;
  logic [ADDR_W-1:0] r_fill_addr;
  logic              r_stage_valid;
  pixel_t            r_stage;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_in_range;
  logic [PIX_W-1:0]  w_fifo_out;
  pixel_t            w_fifo_pix;
  pixel_t            w_in_pix;

  assign ready      = !w_full && (r_state == S_RUN) && !r_clear_pending;
  assign w_push     = writeEn && ready;
  assign w_pop      = ((r_state == S_RUN) || (r_state == S_FLUSH)) && !w_empty;
  assign w_in_pix   = '{x: x, y: y, colour: colour};
  assign w_fifo_pix = pixel_t'(w_fifo_out);
  assign w_in_range = (r_stage.x < c_SCREEN_W) && (r_stage.y < c_SCREEN_H);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_in_pix),
    .pop       (w_pop),
    .pop_data  (w_fifo_out),
    .full      (w_full),
    .empty     (w_empty)
  );

  // The popped pixel sits one cycle in r_stage before reaching the mem port,
  // giving the two-edge accept-to-write latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_RUN;
      r_clear_pending <= 1'b0;
      r_clear_colour  <= '0;
      r_fill_addr     <= '0;
      r_stage_valid   <= 1'b0;
      r_stage         <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_data        <= '0;
      clear_done      <= 1'b0;
      oob_count       <= '0;
    end else begin
      mem_we        <= 1'b0;
      clear_done    <= 1'b0;
      r_stage_valid <= w_pop;
      if (w_pop) r_stage <= w_fifo_pix;

      if (r_stage_valid) begin
        if (w_in_range) begin
          mem_we   <= 1'b1;
          mem_addr <= fb_addr(r_stage.x, r_stage.y);
          mem_data <= r_stage.colour;
        end else if (oob_count != 8'hFF) begin
          oob_count <= oob_count + 8'd1;
        end
      end

      case (r_state)
        S_RUN: begin
          if (clear_req && !r_clear_pending) begin
            r_clear_pending <= 1'b1;
            r_clear_colour  <= clear_colour;
          end
          if (r_clear_pending) begin
            r_fill_addr <= '0;
            r_state     <= w_empty ? S_CLEAR : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_empty) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          // The last flushed pixel may still be in r_stage on the first
          // clear cycle; it owns the mem port, so the fill waits one cycle.
          if (!r_stage_valid) begin
            mem_we   <= 1'b1;
            mem_addr <= r_fill_addr;
            mem_data <= r_clear_colour;
            if (r_fill_addr == c_LAST_ADDR) begin
              r_state    <= S_DONE;
              clear_done <= 1'b1;
            end else begin
              r_fill_addr <= r_fill_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_clear_pending <= 1'b0;
          r_state         <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fb_writer
// Description : Directed self-checking bench for pixel_fb_writer: reset
//               state, single pixel, back-to-back stream, out-of-range
//               handling and saturation, flush-then-fill with a repeated
//               request, and reset during a fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fb_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        ready;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic [7:0]  oob_count;

  always #5 clk = ~clk;

  pixel_fb_writer #(
    .FIFO_DEPTH (4),
    .SCREEN_W   (160),
    .SCREEN_H   (120)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .writeEn      (writeEn),
    .ready        (ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .oob_count    (oob_count)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  cyc      = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Write monitor: logs every framebuffer write and clear_done pulse.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mem_we) wq.push_back('{int'(mem_addr), int'(mem_data), cyc});
    if (clear_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
    x       = xv;
    y       = yv;
    colour  = cv;
    writeEn = 1'b1;
    step();
    writeEn = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int drops;
    int base;
    int n_before;
    int found;
    int last_cyc;
    int span;

    x = '0; y = '0; colour = '0; writeEn = 1'b0;
    clear_req = 1'b0; clear_colour = '0;

    // ---------------- reset state ----------------
    #3;
    check("ready_in_reset", int'(ready), 1);
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_ready", int'(ready), 1);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_data", int'(mem_data), 0);
    check("rst_oob", int'(oob_count), 0);
    check("rst_clear_done", int'(clear_done), 0);

    // ---------------- single pixel (5,3) colour 5 -> addr 485 ----------------
    x = 8'd5; y = 7'd3; colour = 3'b101; writeEn = 1'b1;
    check("single_ready", int'(ready), 1);
    step();
    writeEn = 1'b0;
    check("single_e0_we", int'(mem_we), 0);
    step();
    check("single_e1_we", int'(mem_we), 0);
    step();
    check("single_e2_we", int'(mem_we), 1);
    check("single_addr", int'(mem_addr), 485);
    check("single_data", int'(mem_data), 5);
    step();
    check("single_we_drop", int'(mem_we), 0);
    check("single_addr_hold", int'(mem_addr), 485);
    check("single_data_hold", int'(mem_data), 5);

    // ---------------- back-to-back (10..17, 0) ----------------
    wq.delete();
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      x = 8'(10 + i); y = 7'd0; colour = 3'(i); writeEn = 1'b1;
      if (!ready) drops++;
      step();
    end
    writeEn = 1'b0;
    repeat (4) step();
    check("b2b_ready_drops", drops, 0);
    check("b2b_count", wq.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= wq.size()) errs++;
      else if (wq[i].addr != 10 + i || wq[i].data != (i % 8)) errs++;
    end
    check("b2b_addr_errs", errs, 0);
    span = (wq.size() == 8) ? wq[7].cyc - wq[0].cyc : -1;
    check("b2b_consecutive", span, 7);

    // ---------------- out-of-range and corner ----------------
    wq.delete();
    send(8'd160, 7'd0, 3'd1);
    send(8'd0, 7'd120, 3'd2);
    repeat (4) step();
    check("oob_no_we", wq.size(), 0);
    check("oob_count2", int'(oob_count), 2);
    send(8'd159, 7'd119, 3'd6);
    repeat (4) step();
    check("corner_count", wq.size(), 1);
    check("corner_addr", (wq.size() > 0) ? wq[0].addr : -1, 19199);
    check("oob_unchanged", int'(oob_count), 2);
    for (int i = 0; i < 300; i++) begin
      x = 8'd200; y = 7'd5; colour = 3'd3; writeEn = 1'b1;
      step();
    end
    writeEn = 1'b0;
    repeat (4) step();
    check("oob_saturate", int'(oob_count), 255);

    // ---------------- flush then fill, repeated request ignored ----------------
    wq.delete();
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      x = 8'(20 + i); y = 7'd1; colour = 3'(i + 1); writeEn = 1'b1;
      if (i == 3) begin
        clear_req = 1'b1; clear_colour = 3'b110;
      end
      step();
    end
    writeEn = 1'b0; clear_req = 1'b0;
    check("clear_ready_low", int'(ready), 0);
    repeat (1000) step();
    check("fill_ready_low", int'(ready), 0);
    clear_req = 1'b1; clear_colour = 3'b010;
    step();
    clear_req = 1'b0;
    found = 0;
    for (int k = 0; k < 25000; k++) begin
      if (done_cnt > base) begin
        found = 1;
        break;
      end
      step();
    end
    check("fill_done_seen", found, 1);
    repeat (60) step();
    check("fill_done_count", done_cnt - base, 1);
    check("fill_total_writes", wq.size(), 19204);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= wq.size()) errs++;
      else if (wq[i].addr != 180 + i || wq[i].data != i + 1) errs++;
    end
    check("flush_pixel_errs", errs, 0);
    errs = 0;
    for (int j = 0; j < 19200; j++) begin
      if (4 + j >= wq.size()) errs++;
      else if (wq[4 + j].addr != j || wq[4 + j].data != 6) errs++;
    end
    check("fill_seq_errs", errs, 0);
    last_cyc = (wq.size() >= 19204) ? wq[19203].cyc : -100;
    check("fill_done_after_last", int'(done_cyc - last_cyc >= 0 && done_cyc - last_cyc <= 1), 1);
    span = (wq.size() > 0) ? done_cyc - wq[0].cyc : -1;
    check("fill_done_latency", int'(span >= 19203 && span <= 19210), 1);
    check("ready_after_done", int'(ready), 1);

    // ---------------- reset during fill ----------------
    base = done_cnt;
    clear_req = 1'b1; clear_colour = 3'b011;
    step();
    clear_req = 1'b0;
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      if (mem_we && mem_addr == 15'd1000) begin
        found = 1;
        break;
      end
      step();
    end
    check("rst_fill_reach_1000", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_fill_we", int'(mem_we), 0);
    check("rst_fill_ready", int'(ready), 1);
    check("rst_fill_addr", int'(mem_addr), 0);
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_release_ready", int'(ready), 1);
    n_before = wq.size();
    send(8'd7, 7'd2, 3'd6);
    repeat (4) step();
    check("rst_no_done", done_cnt - base, 0);
    check("post_rst_writes", wq.size() - n_before, 1);
    check("post_rst_addr", (wq.size() > n_before) ? wq[n_before].addr : -1, 327);
    check("post_rst_data", (wq.size() > n_before) ? wq[n_before].data : -1, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
